// File: rtl/dmac_pkg.sv
// Shared types and constants for the read-only DMA controller: modes, FSM states,
// DRAM timing, and the SRAM bank write-enable codes.
package dmac_pkg;

  localparam int ROW_W   = 12;
  localparam int COL_W   = 10;
  localparam int T_RCD   = 2;
  localparam int CAS_LAT = 2;
  localparam int T_RP    = 2;

  typedef enum logic {
    MODE_IMAGE  = 1'b0,
    MODE_WEIGHT = 1'b1
  } dmac_mode_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACT   = 3'd1,
    S_RCD   = 3'd2,
    S_BURST = 3'd3,
    S_PRE   = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6
  } dmac_state_e;

  localparam logic [3:0] WEN_BANK0 = 4'b1110;
  localparam logic [3:0] WEN_BANK1 = 4'b1101;
  localparam logic [3:0] WEN_BANK2 = 4'b1011;
  localparam logic [3:0] WEN_IDLE  = 4'b1111;

  function automatic logic [3:0] bank_wen(input dmac_mode_e mode, input logic bank);
    logic [3:0] wen;
    if (mode == MODE_WEIGHT) begin
      wen = WEN_BANK2;
    end else if (bank) begin
      wen = WEN_BANK1;
    end else begin
      wen = WEN_BANK0;
    end
    return wen;
  endfunction

  // A bank holds at most 4096 words; 0 (or anything larger) selects the full bank.
  function automatic logic [11:0] bank_last_addr(input logic [31:0] sram_size);
    logic [11:0] last;
    if ((sram_size == 32'd0) || (sram_size > 32'd4096)) begin
      last = 12'hFFF;
    end else begin
      last = 12'(sram_size - 32'd1);
    end
    return last;
  endfunction

endpackage

// File: rtl/dmac_dram_rd.sv
// DRAM read sequencer: row activate, column burst and precharge, plus the
// CAS-latency capture pipe that hands each returned word to the SRAM writer.
module dmac_dram_rd
  import dmac_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [21:0] start_addr,
  input  logic [31:0] xfer_size,
  input  logic [31:0] dram_q,
  output logic        dram_csn,
  output logic        dram_rasn,
  output logic        dram_casn,
  output logic [11:0] dram_a,
  output logic [31:0] word,
  output logic        word_vld,
  output logic        busy
);

  localparam logic [1:0] RCD_WAIT = 2'(T_RCD - 2);
  localparam logic [1:0] RP_WAIT  = 2'(T_RP - 1);

  dmac_state_e          state_r, state_nxt_s;
  logic [ROW_W-1:0]     row_r;
  logic [COL_W-1:0]     col_r;
  logic                 col_wrap_r;
  logic [31:0]          issued_r, size_r;
  logic [1:0]           tmr_r, tmr_nxt_s;
  logic                 csn_r, rasn_r, casn_r;
  logic                 csn_nxt_s, rasn_nxt_s, casn_nxt_s;
  logic [11:0]          a_r, a_nxt_s;
  logic                 load_s, issue_s, row_adv_s;
  logic [CAS_LAT-1:0]   vpipe_r;
  logic [31:0]          word_r;
  logic                 word_vld_r;

  // Next-state and next-pin decode; pins are registered so the bus is glitch-free.
  always_comb begin
    state_nxt_s = state_r;
    tmr_nxt_s   = tmr_r;
    csn_nxt_s   = csn_r;
    rasn_nxt_s  = rasn_r;
    casn_nxt_s  = 1'b1;
    a_nxt_s     = a_r;
    load_s      = 1'b0;
    issue_s     = 1'b0;
    row_adv_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (go && (xfer_size != 32'd0)) begin
          load_s      = 1'b1;
          state_nxt_s = S_ACT;
          csn_nxt_s   = 1'b0;
          rasn_nxt_s  = 1'b0;
          a_nxt_s     = start_addr[21:10];
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ACT: begin
        state_nxt_s = S_RCD;
        tmr_nxt_s   = RCD_WAIT;
      end
      S_RCD: begin
        if (tmr_r == 2'd0) begin
          state_nxt_s = S_BURST;
          issue_s     = 1'b1;
          casn_nxt_s  = 1'b0;
          a_nxt_s     = {2'b00, col_r};
        end else begin
          tmr_nxt_s = tmr_r - 2'd1;
        end
      end
      S_BURST: begin
        if ((issued_r != size_r) && !col_wrap_r) begin
          issue_s    = 1'b1;
          casn_nxt_s = 1'b0;
          a_nxt_s    = {2'b00, col_r};
        end else begin
          state_nxt_s = S_PRE;
          rasn_nxt_s  = 1'b1;
          tmr_nxt_s   = RP_WAIT;
        end
      end
      S_PRE: begin
        if (tmr_r != 2'd0) begin
          tmr_nxt_s = tmr_r - 2'd1;
        end else if (issued_r != size_r) begin
          state_nxt_s = S_ACT;
          row_adv_s   = 1'b1;
          rasn_nxt_s  = 1'b0;
          a_nxt_s     = row_r + 12'd1;
        end else begin
          state_nxt_s = S_IDLE;
          csn_nxt_s   = 1'b1;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        csn_nxt_s   = 1'b1;
        rasn_nxt_s  = 1'b1;
      end
    endcase
  end

  // Sequencer state, address counters, DRAM pins and the capture pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      tmr_r      <= 2'd0;
      row_r      <= '0;
      col_r      <= '0;
      col_wrap_r <= 1'b0;
      issued_r   <= 32'd0;
      size_r     <= 32'd0;
      csn_r      <= 1'b1;
      rasn_r     <= 1'b1;
      casn_r     <= 1'b1;
      a_r        <= 12'd0;
      vpipe_r    <= '0;
      word_r     <= 32'd0;
      word_vld_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      tmr_r   <= tmr_nxt_s;
      csn_r   <= csn_nxt_s;
      rasn_r  <= rasn_nxt_s;
      casn_r  <= casn_nxt_s;
      a_r     <= a_nxt_s;
      if (load_s) begin
        row_r      <= start_addr[21:10];
        col_r      <= start_addr[9:0];
        col_wrap_r <= 1'b0;
        issued_r   <= 32'd0;
        size_r     <= xfer_size;
      end else if (issue_s) begin
        // Column 1023 is the last one in the row; the burst must close after it.
        col_wrap_r <= (col_r == 10'h3FF);
        col_r      <= col_r + 10'd1;
        issued_r   <= issued_r + 32'd1;
      end else if (row_adv_s) begin
        row_r      <= row_r + 12'd1;
        col_r      <= '0;
        col_wrap_r <= 1'b0;
      end
      vpipe_r    <= {vpipe_r[CAS_LAT-2:0], issue_s};
      word_vld_r <= vpipe_r[CAS_LAT-1];
      if (vpipe_r[CAS_LAT-1]) begin
        word_r <= dram_q;
      end
    end
  end

  assign dram_csn  = csn_r;
  assign dram_rasn = rasn_r;
  assign dram_casn = casn_r;
  assign dram_a    = a_r;
  assign word      = word_r;
  assign word_vld  = word_vld_r;
  assign busy      = (state_r != S_IDLE);

endmodule

// File: rtl/dmac_ctrl.sv
// Read-only DMA controller top: start/done handshake FSM and the SRAM bank writer,
// fed by the DRAM read sequencer.
module dmac_ctrl
  import dmac_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  Start,
  input  logic [21:0] DRAM_START_A,
  input  logic [31:0] DRAM_SIZE,
  input  logic [31:0] SRAM_SIZE,
  output logic        DRAM_RST,
  output logic        DRAM_CSn,
  output logic        DRAM_RASn,
  output logic        DRAM_CASn,
  output logic [3:0]  DRAM_WEn,
  output logic [11:0] DRAM_A,
  output logic [31:0] DRAM_D,
  input  logic [31:0] DRAM_Q,
  output logic        SRAM_RST,
  output logic        SRAM_CSn,
  output logic [3:0]  SRAM_WEn,
  output logic [11:0] SRAM_Addr,
  output logic [31:0] SRAM_Data,
  output logic        Valid,
  output logic        DMA_Start,
  output logic        DMA_Done
);

  dmac_state_e state_r, state_nxt_s;
  logic        accept_s, done_set_s;
  dmac_mode_e  mode_r;
  logic [31:0] size_r, written_r;
  logic [11:0] last_addr_r, waddr_r;
  logic        bank_r;
  logic        sram_csn_r, valid_r, dma_start_r, dma_done_r;
  logic [3:0]  sram_wen_r;
  logic [11:0] sram_addr_r;
  logic [31:0] sram_data_r;
  logic [31:0] rd_word_s;
  logic        rd_vld_s, rd_busy_s;

  dmac_dram_rd u_rd (
    .clk        (CLK),
    .rst        (RST),
    .go         (accept_s),
    .start_addr (DRAM_START_A),
    .xfer_size  (DRAM_SIZE),
    .dram_q     (DRAM_Q),
    .dram_csn   (DRAM_CSn),
    .dram_rasn  (DRAM_RASn),
    .dram_casn  (DRAM_CASn),
    .dram_a     (DRAM_A),
    .word       (rd_word_s),
    .word_vld   (rd_vld_s),
    .busy       (rd_busy_s)
  );

  // Handshake FSM: S_DRAIN covers the whole transfer, until every word has landed.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    done_set_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (Start[0] && !dma_done_r) begin
          accept_s    = 1'b1;
          state_nxt_s = S_DRAIN;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_DRAIN: begin
        if ((written_r == size_r) && !rd_busy_s) begin
          done_set_s  = 1'b1;
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_DRAIN;
        end
      end
      S_DONE: begin
        state_nxt_s = S_DONE;
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Transfer context, handshake flags and the SRAM write port.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= S_IDLE;
      mode_r      <= MODE_IMAGE;
      size_r      <= 32'd0;
      written_r   <= 32'd0;
      last_addr_r <= 12'd0;
      waddr_r     <= 12'd0;
      bank_r      <= 1'b0;
      sram_csn_r  <= 1'b1;
      sram_wen_r  <= WEN_IDLE;
      sram_addr_r <= 12'd0;
      sram_data_r <= 32'd0;
      valid_r     <= 1'b0;
      dma_start_r <= 1'b0;
      dma_done_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      dma_start_r <= accept_s;
      dma_done_r  <= dma_done_r | done_set_s;
      if (accept_s) begin
        mode_r      <= dmac_mode_e'(Start[1]);
        size_r      <= DRAM_SIZE;
        last_addr_r <= bank_last_addr(SRAM_SIZE);
        written_r   <= 32'd0;
        waddr_r     <= 12'd0;
        bank_r      <= 1'b0;
      end
      if (rd_vld_s) begin
        sram_csn_r  <= 1'b0;
        sram_wen_r  <= bank_wen(mode_r, bank_r);
        sram_addr_r <= waddr_r;
        sram_data_r <= rd_word_s;
        written_r   <= written_r + 32'd1;
        if (waddr_r == last_addr_r) begin
          // Bank full: tell the accelerator, and flip image banks for the next fill.
          valid_r <= 1'b1;
          waddr_r <= 12'd0;
          if (mode_r == MODE_IMAGE) begin
            bank_r <= ~bank_r;
          end
        end else begin
          valid_r <= 1'b0;
          waddr_r <= waddr_r + 12'd1;
        end
      end else begin
        sram_csn_r <= 1'b1;
        sram_wen_r <= WEN_IDLE;
        valid_r    <= 1'b0;
      end
    end
  end

  assign DRAM_RST  = RST;
  assign SRAM_RST  = RST;
  assign DRAM_WEn  = 4'hF;
  assign DRAM_D    = 32'd0;
  assign SRAM_CSn  = sram_csn_r;
  assign SRAM_WEn  = sram_wen_r;
  assign SRAM_Addr = sram_addr_r;
  assign SRAM_Data = sram_data_r;
  assign Valid     = valid_r;
  assign DMA_Start = dma_start_r;
  assign DMA_Done  = dma_done_r;

endmodule

// File: tb/tb_dmac_ctrl.sv
// Directed bench for dmac_ctrl: behavioural DRAM with 2-cycle CAS latency,
// SRAM write logger, and hand-computed expectations per scenario.
module tb_dmac_ctrl;

  logic        CLK, RST;
  logic [1:0]  Start;
  logic [21:0] DRAM_START_A;
  logic [31:0] DRAM_SIZE, SRAM_SIZE;
  logic        DRAM_RST, DRAM_CSn, DRAM_RASn, DRAM_CASn;
  logic [3:0]  DRAM_WEn;
  logic [11:0] DRAM_A;
  logic [31:0] DRAM_D, DRAM_Q;
  logic        SRAM_RST, SRAM_CSn;
  logic [3:0]  SRAM_WEn;
  logic [11:0] SRAM_Addr;
  logic [31:0] SRAM_Data;
  logic        Valid, DMA_Start, DMA_Done;

  dmac_ctrl dut (
    .CLK(CLK), .RST(RST), .Start(Start), .DRAM_START_A(DRAM_START_A),
    .DRAM_SIZE(DRAM_SIZE), .SRAM_SIZE(SRAM_SIZE), .DRAM_RST(DRAM_RST),
    .DRAM_CSn(DRAM_CSn), .DRAM_RASn(DRAM_RASn), .DRAM_CASn(DRAM_CASn),
    .DRAM_WEn(DRAM_WEn), .DRAM_A(DRAM_A), .DRAM_D(DRAM_D), .DRAM_Q(DRAM_Q),
    .SRAM_RST(SRAM_RST), .SRAM_CSn(SRAM_CSn), .SRAM_WEn(SRAM_WEn),
    .SRAM_Addr(SRAM_Addr), .SRAM_Data(SRAM_Data), .Valid(Valid),
    .DMA_Start(DMA_Start), .DMA_Done(DMA_Done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  int cs_cnt, start_cnt, valid_cnt, act_cnt, cas_cnt, wr_cnt, bad_a;
  logic [11:0] row_l;
  logic        ras_prev;
  logic [31:0] pend_q;
  logic [21:0] cas_log [0:15];
  logic [3:0]  wl_wen  [0:511];
  logic [11:0] wl_addr [0:511];
  logic [31:0] wl_data [0:511];

  function automatic logic [31:0] dram_word(input logic [21:0] a);
    return {10'h2B5, a};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // DRAM model and bus monitors, sampled mid-cycle on the falling edge
  always @(negedge CLK) begin
    if (!DRAM_CSn) cs_cnt++;
    if (DMA_Start) start_cnt++;
    if (Valid) valid_cnt++;
    if (!DRAM_RASn && ras_prev) begin
      row_l = DRAM_A;
      act_cnt++;
    end
    ras_prev = DRAM_RASn;
    DRAM_Q <= pend_q;
    if (!DRAM_CASn) begin
      if (cas_cnt < 16) cas_log[cas_cnt] = {row_l, DRAM_A[9:0]};
      if (DRAM_A[11:10] != 2'b00) bad_a++;
      pend_q <= dram_word({row_l, DRAM_A[9:0]});
      cas_cnt++;
    end else begin
      pend_q <= 32'hDEAD_BEEF;
    end
    if (!SRAM_CSn) begin
      if (wr_cnt < 512) begin
        wl_wen[wr_cnt]  = SRAM_WEn;
        wl_addr[wr_cnt] = SRAM_Addr;
        wl_data[wr_cnt] = SRAM_Data;
      end
      wr_cnt++;
    end
  end

  task automatic clear_stats();
    cs_cnt = 0; start_cnt = 0; valid_cnt = 0; act_cnt = 0;
    cas_cnt = 0; wr_cnt = 0; bad_a = 0;
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, " dram_csn"},  32'(DRAM_CSn), 32'd1);
    check_eq({tag, " dram_rasn"}, 32'(DRAM_RASn), 32'd1);
    check_eq({tag, " dram_casn"}, 32'(DRAM_CASn), 32'd1);
    check_eq({tag, " dram_wen"},  32'(DRAM_WEn), 32'hF);
    check_eq({tag, " dram_a"},    32'(DRAM_A), 32'd0);
    check_eq({tag, " dram_d"},    DRAM_D, 32'd0);
    check_eq({tag, " sram_csn"},  32'(SRAM_CSn), 32'd1);
    check_eq({tag, " sram_wen"},  32'(SRAM_WEn), 32'hF);
    check_eq({tag, " sram_addr"}, 32'(SRAM_Addr), 32'd0);
    check_eq({tag, " sram_data"}, SRAM_Data, 32'd0);
    check_eq({tag, " flags"},     32'({Valid, DMA_Start, DMA_Done}), 32'd0);
    check_eq({tag, " rst_out"},   32'({DRAM_RST, SRAM_RST}), 32'd3);
  endtask

  task automatic do_reset(input string tag);
    Start = 2'b00;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_outs(tag);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    clear_stats();
  endtask

  task automatic start_xfer(input logic [1:0] st, input logic [21:0] a,
                            input logic [31:0] dsz, input logic [31:0] ssz);
    @(posedge CLK);
    #1;
    DRAM_START_A = a;
    DRAM_SIZE = dsz;
    SRAM_SIZE = ssz;
    Start = st;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!DMA_Done && (n < budget)) begin
      @(negedge CLK);
      n++;
    end
    check_eq(tag, 32'(DMA_Done), 32'd1);
    repeat (2) @(negedge CLK);
  endtask

  // Compares the SRAM write log against the expected data, address and bank per word
  task automatic verify_log(input string tag, input logic [21:0] base, input int n,
                            input int ssz, input bit image);
    int bad;
    logic [3:0] ew;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (!image) ew = 4'b1011;
      else if (((i / ssz) % 2) == 1) ew = 4'b1101;
      else ew = 4'b1110;
      if (wl_data[i] !== dram_word(22'(base + 22'(i)))) bad++;
      if (wl_addr[i] !== 12'(i % ssz)) bad++;
      if (wl_wen[i] !== ew) bad++;
    end
    check_eq({tag, " log_mismatches"}, 32'(bad), 32'd0);
  endtask

  initial begin
    RST = 1'b1; Start = 2'b00; DRAM_START_A = 22'd0; DRAM_SIZE = 32'd0; SRAM_SIZE = 32'd0;
    DRAM_Q = 32'd0; pend_q = 32'd0; row_l = 12'd0; ras_prev = 1'b1;
    clear_stats();
    do_reset("reset");

    // No go bit: nothing may happen
    Start = 2'b00;
    repeat (20) @(posedge CLK);
    #1 Start = 2'b10;
    repeat (20) @(posedge CLK);
    repeat (2) @(negedge CLK);
    check_eq("nogo cs_activity", 32'(cs_cnt), 32'd0);
    check_eq("nogo dma_start",   32'(start_cnt), 32'd0);

    // Zero-length transfer
    start_xfer(2'b01, 22'd0, 32'd0, 32'd16);
    @(posedge CLK);
    @(negedge CLK);
    check_eq("zero start_pulse", 32'({DMA_Start, DMA_Done}), 32'b10);
    @(negedge CLK);
    check_eq("zero done_next",   32'({DMA_Start, DMA_Done}), 32'b01);
    repeat (10) @(negedge CLK);
    check_eq("zero done_held",   32'(DMA_Done), 32'd1);
    check_eq("zero start_once",  32'(start_cnt), 32'd1);
    check_eq("zero no_writes",   32'(wr_cnt), 32'd0);
    check_eq("zero no_dram",     32'(cs_cnt), 32'd0);

    // Weight mode, one full bank2 fill
    do_reset("reset2");
    start_xfer(2'b11, 22'h100000, 32'd432, 32'd432);
    wait_done("wt done", 3000);
    check_eq("wt start_once", 32'(start_cnt), 32'd1);
    check_eq("wt valid_once", 32'(valid_cnt), 32'd1);
    check_eq("wt writes",     32'(wr_cnt), 32'd432);
    check_eq("wt cas",        32'(cas_cnt), 32'd432);
    check_eq("wt last_word",  wl_data[431], dram_word(22'h1001AF));
    verify_log("wt", 22'h100000, 432, 432, 1'b0);
    repeat (10) @(negedge CLK);
    check_eq("wt done_held",  32'(DMA_Done), 32'd1);
    check_eq("wt no_retrig",  32'(start_cnt), 32'd1);

    // Image mode ping-pong: 12 words into 4-word banks
    do_reset("reset3");
    start_xfer(2'b01, 22'd0, 32'd12, 32'd4);
    wait_done("img done", 500);
    check_eq("img valid_x3", 32'(valid_cnt), 32'd3);
    check_eq("img writes",   32'(wr_cnt), 32'd12);
    verify_log("img", 22'd0, 12, 4, 1'b1);

    // Row crossing: cols 0x3FE,0x3FF of row 0 then cols 0,1 of row 1
    do_reset("reset4");
    start_xfer(2'b01, 22'h0003FE, 32'd4, 32'd16);
    wait_done("row done", 500);
    check_eq("row cas_count", 32'(cas_cnt), 32'd4);
    check_eq("row act_count", 32'(act_cnt), 32'd2);
    check_eq("row cas0", 32'(cas_log[0]), 32'h3FE);
    check_eq("row cas1", 32'(cas_log[1]), 32'h3FF);
    check_eq("row cas2", 32'(cas_log[2]), 32'h400);
    check_eq("row cas3", 32'(cas_log[3]), 32'h401);
    check_eq("row a_hi_zero", 32'(bad_a), 32'd0);
    verify_log("row", 22'h0003FE, 4, 16, 1'b1);

    // Reset in the middle of a burst, then restart
    do_reset("reset5");
    start_xfer(2'b01, 22'd0, 32'd100, 32'd0);
    for (int n = 0; (n < 300) && (wr_cnt < 3); n++) @(negedge CLK);
    check_eq("mid reached_burst", 32'(wr_cnt >= 3), 32'd1);
    @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check_reset_outs("midrst");
    @(posedge CLK);
    #1 RST = 1'b0;
    Start = 2'b00;
    clear_stats();
    start_xfer(2'b01, 22'h000200, 32'd5, 32'd0);
    wait_done("restart done", 500);
    check_eq("restart writes", 32'(wr_cnt), 32'd5);
    verify_log("restart", 22'h000200, 5, 4096, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
